// File: rtl/dm_cache_pkg.sv
// Shared types and widths for the direct-mapped write-back cache controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package dm_cache_pkg;

    localparam int ADDR_W     = 30;
    localparam int BLK_ADDR_W = 28;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 128;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    function automatic int tag_w(input int index_w);
        return BLK_ADDR_W - index_w;
    endfunction

endpackage

// File: rtl/dm_cache_if.sv
// Processor load/store port and slow block-memory handshake bundled together.
// Latency: n/a (wiring only).
// Backpressure: proc_stall towards the processor, mem_ready from memory.
interface dm_cache_if;

    logic                               proc_read;
    logic                               proc_write;
    logic [dm_cache_pkg::ADDR_W-1:0]     proc_addr;
    logic [dm_cache_pkg::WORD_W-1:0]     proc_wdata;
    logic [dm_cache_pkg::WORD_W-1:0]     proc_rdata;
    logic                               proc_stall;
    logic                               mem_read;
    logic                               mem_write;
    logic [dm_cache_pkg::BLK_ADDR_W-1:0] mem_addr;
    logic [dm_cache_pkg::LINE_W-1:0]     mem_wdata;
    logic [dm_cache_pkg::LINE_W-1:0]     mem_rdata;
    logic                               mem_ready;

    modport master (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dm_cache_tagstore.sv
// Valid/dirty/tag arrays with a combinational hit compare on the presented index.
// Latency: compare is combinational; updates land at the next posedge.
// Backpressure: none; the controller decides when fill/set_dirty fire.
module dm_cache_tagstore #(
    parameter int NUM_BLOCKS = 8,
    parameter int INDEX_W    = 3,
    parameter int TAG_W      = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    input  logic               fill,
    input  logic               set_dirty,
    output logic               hit,
    output logic               victim_valid,
    output logic               victim_dirty,
    output logic [TAG_W-1:0]   victim_tag
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q [NUM_BLOCKS];

    assign victim_valid = valid_q[index];
    assign victim_dirty = dirty_q[index];
    assign victim_tag   = tag_q[index];
    assign hit          = victim_valid && (victim_tag == tag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tag_q[i] <= '0;
            end
        end else if (fill) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
            tag_q[index]   <= tag;
        end else if (set_dirty) begin
            dirty_q[index] <= 1'b1;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller; DM_CACHE_STATS_EN adds hit/miss counters.
// Latency: hits complete in the presenting cycle; misses cost COMPARE + [WRITEBACK] + ALLOCATE.
// Backpressure: proc_stall held while a block transfer waits on mem_ready.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int INDEX_W    = $clog2(NUM_BLOCKS)
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_cache_if.master  bus
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAG_W = tag_w(INDEX_W);

    state_t             state_q;
    state_t             state_nxt;
    logic               req;
    logic               hit;
    logic               victim_valid;
    logic               victim_dirty;
    logic [TAG_W-1:0]   victim_tag;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [1:0]         req_off;
    logic               fill;
    logic               set_dirty;
    logic [LINE_W-1:0]  data_q [NUM_BLOCKS];
    logic [LINE_W-1:0]  cur_line;

    assign req       = bus.proc_read || bus.proc_write;
    assign req_tag   = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign req_index = bus.proc_addr[2 +: INDEX_W];
    assign req_off   = bus.proc_addr[1:0];
    assign cur_line  = data_q[req_index];

    dm_cache_tagstore #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .INDEX_W    (INDEX_W),
        .TAG_W      (TAG_W)
    ) u_tagstore (
        .clk          (clk),
        .rst_n        (rst_n),
        .index        (req_index),
        .tag          (req_tag),
        .fill         (fill),
        .set_dirty    (set_dirty),
        .hit          (hit),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COMPARE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Memory requests depend on state alone, so they stay stable for the whole transfer.
    always_comb begin
        state_nxt      = state_q;
        fill           = 1'b0;
        set_dirty      = 1'b0;
        bus.proc_stall = 1'b0;
        bus.proc_rdata = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        case (state_q)
            COMPARE: begin
                if (req) begin
                    if (hit) begin
                        bus.proc_rdata = cur_line[{req_off, 5'd0} +: WORD_W];
                        set_dirty      = bus.proc_write;
                    end else begin
                        bus.proc_stall = 1'b1;
                        state_nxt      = (victim_valid && victim_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.proc_stall = 1'b1;
                bus.mem_write  = 1'b1;
                bus.mem_addr   = {victim_tag, req_index};
                bus.mem_wdata  = cur_line;
                if (bus.mem_ready) begin
                    state_nxt = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.proc_stall = 1'b1;
                bus.mem_read   = 1'b1;
                bus.mem_addr   = bus.proc_addr[ADDR_W-1:2];
                if (bus.mem_ready) begin
                    fill      = 1'b1;
                    state_nxt = COMPARE;
                end
            end
            default: state_nxt = COMPARE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                data_q[i] <= '0;
            end
        end else if (fill) begin
            data_q[req_index] <= bus.mem_rdata;
        end else if (set_dirty) begin
            data_q[req_index][{req_off, 5'd0} +: WORD_W] <= bus.proc_wdata;
        end
    end

`ifdef DM_CACHE_STATS_EN
    // retry_q marks a request that already missed, so its final hit is not counted.
    logic retry_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            retry_q  <= 1'b0;
        end else if (state_q == COMPARE && req) begin
            if (hit) begin
                retry_q <= 1'b0;
                if (!retry_q && hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end
            end else begin
                retry_q <= 1'b1;
                if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule
